// File: rtl/sys_array_stream.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine with streaming inputs.
// Define SYS_ARRAY_SAT_EN to clamp each result lane to the signed 2*DATA_WIDTH range.
module sys_array_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(COLS),
  localparam int unsigned LATENCY   = ROWS + COLS
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                w_valid,
  output logic                                w_ready,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]     w_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]     in_data,
  output logic                                out_valid,
  output logic [ROWS-1:0][ACC_WIDTH-1:0]      out_data
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CntW  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StEmpty, StLoad, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic            w_we;
  logic            in_acc;

  // Control FSM
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    w_ready     = 1'b0;
    in_ready    = 1'b0;
    w_we        = 1'b0;
    unique case (state_q)
      StEmpty, StLoad: begin
        // Row counter is zero in StEmpty, so both states share the fill logic.
        w_ready = 1'b1;
        if (w_valid) begin
          w_we = 1'b1;
          if (row_cnt_q == RowW'(ROWS - 1)) begin
            row_cnt_d = '0;
            state_d   = StRun;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
            state_d   = StLoad;
          end
        end
      end
      StRun: begin
        in_ready = 1'b1;
        if (w_valid) begin
          state_d     = StDrain;
          drain_cnt_d = CntW'(LATENCY);
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q <= CntW'(1)) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StEmpty;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign in_acc = in_valid & in_ready;

  // Datapath state
  logic signed [DATA_WIDTH-1:0] w_q   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] sk_q  [COLS][COLS];
  logic signed [DATA_WIDTH-1:0] x_q   [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  ps_q  [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  dk_q  [ROWS][ROWS];
  logic signed [ACC_WIDTH-1:0]  out_q [ROWS];
  logic [LATENCY-1:0]           vld_q;

  logic signed [DATA_WIDTH-1:0] x_in    [COLS];
  logic signed [DATA_WIDTH-1:0] feed    [COLS];
  logic signed [DATA_WIDTH-1:0] xc      [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  pc      [ROWS][COLS];
  logic signed [ProdW-1:0]      prod    [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  cell_ps [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  row_out [ROWS];
  logic signed [ACC_WIDTH-1:0]  res     [ROWS];

`ifdef SYS_ARRAY_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'({1'b0, {(ProdW - 1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;
`endif

  always_comb begin
    // Unaccepted cycles inject zeros so idle pipeline slots carry no stale data.
    for (int j = 0; j < COLS; j++) begin
      x_in[j] = in_acc ? signed'(in_data[j]) : '0;
    end
    feed[0] = x_in[0];
    for (int j = 1; j < COLS; j++) begin
      feed[j] = sk_q[j][j-1];
    end
    for (int j = 0; j < COLS; j++) begin
      xc[0][j] = feed[j];
      for (int i = 1; i < ROWS; i++) begin
        xc[i][j] = x_q[i-1][j];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      pc[i][0] = '0;
      for (int j = 1; j < COLS; j++) begin
        pc[i][j] = ps_q[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
        prod[i][j]    = ProdW'(w_q[i][j]) * ProdW'(xc[i][j]);
        cell_ps[i][j] = pc[i][j] + ACC_WIDTH'(prod[i][j]);
      end
    end
    // Row i leaves the grid ROWS-1-i cycles before the last row does.
    row_out[ROWS-1] = ps_q[ROWS-1][COLS-1];
    for (int i = 0; i + 1 < ROWS; i++) begin
      row_out[i] = dk_q[i][ROWS-2-i];
    end
    for (int i = 0; i < ROWS; i++) begin
`ifdef SYS_ARRAY_SAT_EN
      if (row_out[i] > SatMax) begin
        res[i] = SatMax;
      end else if (row_out[i] < SatMin) begin
        res[i] = SatMin;
      end else begin
        res[i] = row_out[i];
      end
`else
      res[i] = row_out[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_q   <= '{default: '0};
      sk_q  <= '{default: '0};
      x_q   <= '{default: '0};
      ps_q  <= '{default: '0};
      dk_q  <= '{default: '0};
      out_q <= '{default: '0};
      vld_q <= '0;
    end else begin
      if (w_we) begin
        for (int j = 0; j < COLS; j++) begin
          w_q[row_cnt_q][j] <= signed'(w_data[j]);
        end
      end
      for (int j = 0; j < COLS; j++) begin
        sk_q[j][0] <= x_in[j];
        for (int k = 1; k < COLS; k++) begin
          sk_q[j][k] <= sk_q[j][k-1];
        end
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          x_q[i][j]  <= xc[i][j];
          ps_q[i][j] <= cell_ps[i][j];
        end
        dk_q[i][0] <= ps_q[i][COLS-1];
        for (int k = 1; k < ROWS; k++) begin
          dk_q[i][k] <= dk_q[i][k-1];
        end
        out_q[i] <= res[i];
      end
      vld_q <= {vld_q[LATENCY-2:0], in_acc};
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      out_data[i] = out_q[i];
    end
  end

  assign out_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_sys_array_stream.sv
// Directed bench for sys_array_stream with a timestamped scoreboard of expected results.
module tb_sys_array_stream;

  localparam int DW  = 8;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int AW  = 18;
  localparam int LAT = 8;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  w_valid;
  logic                  w_ready;
  logic [C-1:0][DW-1:0]  w_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [C-1:0][DW-1:0]  in_data;
  logic                  out_valid;
  logic [R-1:0][AW-1:0]  out_data;

  always #5 clk = ~clk;

  sys_array_stream #(
    .DATA_WIDTH(DW),
    .ROWS      (R),
    .COLS      (C)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  typedef logic [R-1:0][AW-1:0] vec_t;
  typedef struct {
    vec_t y;
    int   t;
  } exp_t;

  exp_t sb[$];
  int   wm[R][C];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t model(input int x[C]);
    vec_t y;
    for (int i = 0; i < R; i++) begin
      int s;
      s = 0;
      for (int j = 0; j < C; j++) s += wm[i][j] * x[j];
`ifdef SYS_ARRAY_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      y[i] = AW'(s);
    end
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector for one cycle; optionally request a reload in the same cycle.
  task automatic send(input int x[C], input bit also_w, input bit do_push);
    exp_t e;
    chk("in_ready_at_send", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    w_valid  = also_w;
    for (int j = 0; j < C; j++) in_data[j] = DW'(x[j]);
    if (do_push) begin
      e.y = model(x);
      e.t = cyc + LAT;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
    w_valid  = 1'b0;
  endtask

  task automatic load(input int m[R][C]);
    for (int r = 0; r < R; r++) begin
      chk("w_ready_during_load", 64'(w_ready), 64'd1);
      chk("in_ready_during_load", 64'(in_ready), 64'd0);
      w_valid = 1'b1;
      for (int j = 0; j < C; j++) w_data[j] = DW'(m[r][j]);
      step();
    end
    w_valid = 1'b0;
    wm = m;
    chk("in_ready_after_load", 64'(in_ready), 64'd1);
    chk("w_ready_after_load", 64'(w_ready), 64'd0);
  endtask

  // Called right after the edge that accepted a reload request in RUN.
  task automatic drain();
    for (int k = 0; k < LAT; k++) begin
      chk("in_ready_drain", 64'(in_ready), 64'd0);
      chk("w_ready_drain", 64'(w_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = '1;
      step();
    end
    in_valid = 1'b0;
    chk("w_ready_after_drain", 64'(w_ready), 64'd1);
    chk("in_ready_after_drain", 64'(in_ready), 64'd0);
  endtask

  task automatic request_drain();
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    drain();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].t < cyc) begin
      n_cmp++;
      assert (sb[0].t >= cyc) else begin
        n_err++;
        $error("FAIL missing_out_valid: observed none by cycle %0d expected at %0d", cyc, sb[0].t);
      end
      void'(sb.pop_front());
    end
    if (out_valid !== 1'b0) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_out_valid: observed out_valid=%b expected 0 at cycle %0d",
               out_valid, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert (out_data === e.y) else begin
          n_err++;
          $error("FAIL out_data: observed %h expected %h", out_data, e.y);
        end
        n_cmp++;
        assert (cyc === e.t) else begin
          n_err++;
          $error("FAIL out_timing: observed cycle %0d expected cycle %0d", cyc, e.t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ident[R][C];
    int ones[R][C];
    int neg[R][C];
    int rnd[R][C];
    int x[C];

    reset_n  = 1'b0;
    w_valid  = 1'b0;
    w_data   = '0;
    in_valid = 1'b1;
    in_data  = '1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd1);
    n_cmp++;
    assert (out_data === '0) else begin
      n_err++;
      $error("FAIL rst_out_data: observed %h expected 0", out_data);
    end
    reset_n = 1'b1;
    step();
    in_valid = 1'b0;
    chk("empty_ignores_in_valid", 64'(in_ready), 64'd0);
    chk("empty_w_ready", 64'(w_ready), 64'd1);

    // Identity weights
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) ident[i][j] = (i == j) ? 1 : 0;
    load(ident);
    x = '{1, -2, 3, 127};
    send(x, 1'b0, 1'b1);
    idle(12);

    // Streaming with all-ones weights
    request_drain();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) ones[i][j] = 1;
    load(ones);
    for (int k = 1; k <= 4; k++) begin
      x = '{k, k, k, k};
      send(x, 1'b0, 1'b1);
    end
    idle(12);

    // Extreme negative operands
    request_drain();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) neg[i][j] = -128;
    load(neg);
    x = '{-128, -128, -128, -128};
    send(x, 1'b0, 1'b1);
    x = '{127, -128, 127, -128};
    send(x, 1'b0, 1'b1);
    idle(12);

    // Reload requested alongside the third vector of a stream
    request_drain();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) rnd[i][j] = int'($urandom_range(0, 255)) - 128;
    load(rnd);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < C; j++) x[j] = int'($urandom_range(0, 255)) - 128;
      send(x, (k == 2), 1'b1);
    end
    drain();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) rnd[i][j] = int'($urandom_range(0, 255)) - 128;
    load(rnd);
    for (int j = 0; j < C; j++) x[j] = int'($urandom_range(0, 255)) - 128;
    send(x, 1'b0, 1'b1);
    x = '{-1, 2, -3, 4};
    send(x, 1'b0, 1'b1);
    idle(12);

    // Mid-stream reset discards in-flight vectors
    x = '{5, 6, 7, 8};
    send(x, 1'b0, 1'b0);
    send(x, 1'b0, 1'b0);
    idle(2);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) wm[i][j] = 0;
    for (int k = 0; k < 20; k++) begin
      chk("post_reset_no_valid", 64'(out_valid), 64'd0);
      step();
    end
    chk("post_reset_w_ready", 64'(w_ready), 64'd1);
    chk("post_reset_in_ready", 64'(in_ready), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
